// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes, master FSM state encoding, frame length.
// Used by spi_master and the SPI slave opcode decode.
package spi_pkg;

  localparam int CMD_BITS = 10;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RECV  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  function automatic logic is_rd_data(
    input logic [1:0] op
  );
    return op == OP_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_master.sv
// SPI initiator: serialises {op,payload} MSB-first under SS_n and returns
// the MISO reply of RD_DATA frames.
// Ports: clk, rst (sync, high); cmd_valid/cmd_ready/cmd_op/cmd_data host
// command; rsp_valid/rsp_data read reply; SS_n/MOSI/MISO serial side.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  logic [2:0]          state;
  logic [3:0]          cnt;
  logic [1:0]          op;
  logic [CMD_BITS-1:0] tx;
  logic [7:0]          rx;

  assign cmd_ready = (state == ST_IDLE);
  assign SS_n = (state == ST_IDLE) || (state == ST_GAP);
  // START repeats op[1] ahead of the full frame: slave's r/w selector.
  assign MOSI = ((state == ST_START) || (state == ST_SHIFT))
              ? tx[CMD_BITS-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op        <= '0;
      tx        <= '0;
      rx        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            tx    <= {cmd_op, cmd_data};
            op    <= cmd_op;
            state <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= 4'(CMD_BITS - 1);
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          tx <= {tx[CMD_BITS-2:0], 1'b0};
          if (cnt == '0) begin
            if (is_rd_data(op)) begin
              cnt   <= 4'(RD_WAIT - 1);
              state <= ST_WAIT;
            end else begin
              cnt   <= 4'(GAP - 1);
              state <= ST_GAP;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            cnt   <= 4'd7;
            state <= ST_RECV;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RECV: begin
          rx <= {rx[6:0], MISO};
          // rsp_data only moves once the whole byte is in.
          if (cnt == '0) begin
            rsp_data  <= {rx[6:0], MISO};
            rsp_valid <= 1'b1;
            cnt       <= 4'(GAP - 1);
            state     <= ST_GAP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: frame-level SPI slave model,
// table vectors, random commands and reset/back-to-back corner cases.
module tb_spi_master;
  import spi_pkg::*;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  spi_master #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [7:0] model_rsp = 8'h00;
  int accept_cyc = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [7:0] reply;
    int         exp_len;
    logic [7:0] exp_rsp;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pack(input logic s, input logic m,
                                       input logic r, input logic v,
                                       input logic [7:0] d);
    return {s, m, r, v, d};
  endfunction

  function automatic logic [11:0] obs();
    return pack(SS_n, MOSI, cmd_ready, rsp_valid, rsp_data);
  endfunction

  // One full transaction checked cycle by cycle against the frame rules:
  // 1 selector bit + 10 frame bits, then RD_WAIT idle + 8 reply bits for
  // RD_DATA, then GAP cycles with SS_n high.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                         input logic [7:0] reply, input bit hold,
                         input logic [1:0] nop, input logic [7:0] ndata,
                         output int lowcnt, output logic [7:0] rsp_end);
    bit rd;
    int len;
    int rstart;
    logic [9:0] word;
    logic [9:0] rxw;
    logic [11:0] exp;
    logic em;
    logic [7:0] ed;
    bit q[$];
    bit ok;
    rd = (op == 2'b11);
    word = {op, data};
    len = rd ? (11 + RD_WAIT + 8) : 11;
    rstart = 12 + RD_WAIT;
    lowcnt = 0;
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 64; w++) begin
      MISO = 1'($urandom);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      rsp_end = rsp_data;
      return;
    end
    accept_cyc = cyc;
    step();
    cmd_valid = hold;
    cmd_op = nop;
    cmd_data = ndata;
    for (int j = 1; j <= len + GAP; j++) begin
      if (rd && j >= rstart && j < rstart + 8)
        MISO = reply[7 - (j - rstart)];
      else
        MISO = 1'($urandom);
      if (j == 1) em = op[1];
      else if (j <= 11) em = word[11 - j];
      else em = 1'b0;
      ed = (rd && j > len) ? reply : model_rsp;
      exp = pack(j > len, em, 1'b0, rd && (j == len + 1), ed);
      if (!SS_n) begin
        lowcnt++;
        q.push_back(MOSI);
      end
      check($sformatf("frame op%0d j%0d", op, j), 32'(obs()), 32'(exp));
      step();
    end
    MISO = 1'($urandom);
    check("ready_after_gap", 32'(cmd_ready), 32'd1);
    rxw = '0;
    for (int i = 1; i <= 10; i++)
      if (i < q.size()) rxw = {rxw[8:0], q[i]};
    check("slave_rx_data", 32'(rxw), 32'(word));
    if (rd) model_rsp = reply;
    rsp_end = rsp_data;
  endtask

  int lc;
  int a1;
  logic [7:0] re;
  logic [1:0] rop;
  logic [7:0] rdat;
  logic [7:0] rrep;

  initial begin
    tbl[0] = '{2'b11, 8'h00, 8'h5A, 11 + RD_WAIT + 8, 8'h5A};
    tbl[1] = '{2'b00, 8'hFF, 8'h00, 11, 8'h5A};
    tbl[2] = '{2'b10, 8'h81, 8'hAA, 11, 8'h5A};
    tbl[3] = '{2'b11, 8'h77, 8'hFF, 11 + RD_WAIT + 8, 8'hFF};
    tbl[4] = '{2'b01, 8'h01, 8'h00, 11, 8'hFF};
    tbl[5] = '{2'b11, 8'hE0, 8'h00, 11 + RD_WAIT + 8, 8'h00};

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    model_rsp = 8'h00;

    for (int i = 0; i < 20; i++) begin
      MISO = 1'($urandom);
      check($sformatf("idle %0d", i), 32'(obs()),
            32'(pack(1'b1, 1'b0, 1'b1, 1'b0, 8'h00)));
      step();
    end

    run_cmd(2'b00, 8'hA5, 8'h00, 1'b0, 2'b00, 8'h00, lc, re);
    check("wr_addr_low_len", 32'(lc), 32'd11);

    // Abort a read in its 5th RECV cycle.
    cmd_op = 2'b11;
    cmd_data = 8'h00;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int j = 1; j < 12 + RD_WAIT + 4; j++) begin
      MISO = 1'($urandom);
      step();
    end
    check("recv5_ss_low", 32'(SS_n), 32'd0);
    rst = 1'b1;
    step();
    check("rst_mid_recv", 32'(obs()),
          32'(pack(1'b1, 1'b0, 1'b1, 1'b0, 8'h00)));
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      MISO = 1'($urandom);
      step();
      check($sformatf("post_rst %0d", i), 32'(obs()),
            32'(pack(1'b1, 1'b0, 1'b1, 1'b0, 8'h00)));
    end
    model_rsp = 8'h00;
    run_cmd(2'b00, 8'h5C, 8'h00, 1'b0, 2'b00, 8'h00, lc, re);

    // Back-to-back with the next command held during the first frame.
    run_cmd(2'b01, 8'h3C, 8'h00, 1'b1, 2'b10, 8'h10, lc, re);
    a1 = accept_cyc;
    run_cmd(2'b10, 8'h10, 8'h00, 1'b0, 2'b00, 8'h00, lc, re);
    check("b2b_period", 32'(accept_cyc - a1), 32'(11 + GAP + 1));

    run_cmd(2'b11, 8'h00, 8'hC3, 1'b0, 2'b00, 8'h00, lc, re);
    check("rd_low_len", 32'(lc), 32'd21);
    check("rd_rsp_c3", 32'(re), 32'h0C3);

    for (int i = 0; i < 6; i++) begin
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].reply, 1'b0, 2'b00, 8'h00,
              lc, re);
      check($sformatf("tbl%0d_len", i), 32'(lc), 32'(tbl[i].exp_len));
      check($sformatf("tbl%0d_rsp", i), 32'(re), 32'(tbl[i].exp_rsp));
    end

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      rdat = 8'($urandom);
      rrep = 8'($urandom);
      run_cmd(rop, rdat, rrep, 1'b0, 2'b00, 8'h00, lc, re);
      check($sformatf("rnd%0d_rsp", i), 32'(re), 32'(model_rsp));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
